// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port sync RAM between
// the CPU bus (port A) and the loader/debug port (port B).
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  grant_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   pick_b;

  // Port B wins when it is the only requester, or on a tie when A went last.
  always_comb begin
    pick_b = b_req & (~a_req | ~grant_b);
  end

  // Transaction sequencer: grant, issue to RAM, capture read data, ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
      grant_b   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            grant_b   <= pick_b;
            ram_addr  <= pick_b ? b_addr  : a_addr;
            ram_wdata <= pick_b ? b_wdata : a_wdata;
            ram_we    <= pick_b ? b_we    : a_we;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // RAM samples we/addr at this edge; write strobe lasts one cycle.
          ram_we <= 1'b0;
          state  <= DATA;
        end
        DATA: begin
          // Registered RAM output is valid now; hand it to the owner.
          if (grant_b) begin
            b_rdata <= ram_rdata;
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= ram_rdata;
            a_ack   <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural 16x8 sync RAM.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic       busy, grant_b;

  logic [7:0] mem [16] = '{8'h1F, 8'h11, 8'h22, 8'h86, 8'h44, 8'h55, 8'h66, 8'h00,
                           8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0A, 8'hFF};

  typedef struct {
    bit         port;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ack_cnt = 0;
  int   we_cnt = 0;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  // Single-port RAM, registered read-old output.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic push(input bit port, input logic [7:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Pops the expected queue on every ack the DUT presents.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (a_ack || b_ack) begin
        ack_cnt++;
        if (a_ack && b_ack) chk("dual_ack", 32'(1), 32'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'({a_ack, b_ack}), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ack_port", 32'(b_ack), 32'(e.port));
          chk("ack_data", 32'(b_ack ? b_rdata : a_rdata), 32'(e.data));
        end
      end
    end
  endtask

  task automatic wait_acks(input int n);
    int target;
    int k;
    target = ack_cnt + n;
    k = 0;
    while (ack_cnt < target && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (ack_cnt < target) chk("ack_timeout", 32'(ack_cnt), 32'(target));
  endtask

  task automatic set_a(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    reset = 1'b1;
    set_a(1'b0, 1'b0, 4'h0, 8'h00);
    set_b(1'b0, 1'b0, 4'h0, 8'h00);
    fork
      monitor();
    join_none
    idle_cycles(2);

    // Reset values
    chk("rst_ram_we", 32'(ram_we), 32'(0));
    chk("rst_ram_addr", 32'(ram_addr), 32'(0));
    chk("rst_ram_wdata", 32'(ram_wdata), 32'(0));
    chk("rst_acks", 32'({a_ack, b_ack}), 32'(0));
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_grant_b", 32'(grant_b), 32'(1));
    reset = 1'b0;
    idle_cycles(1);

    // 1: A reads 0xE, ack on third cycle after the grant edge
    push(1'b0, 8'h0A);
    set_a(1'b1, 1'b0, 4'hE, 8'h00);
    idle_cycles(1);
    chk("t1_ram_addr", 32'(ram_addr), 32'(4'hE));
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_grant_b", 32'(grant_b), 32'(0));
    idle_cycles(1);
    chk("t1_ack_early", 32'(a_ack), 32'(0));
    idle_cycles(1);
    chk("t1_ack_lat", 32'(a_ack), 32'(1));
    a_req = 1'b0;
    idle_cycles(2);
    chk("t1_ack_pulse", 32'(a_ack), 32'(0));
    chk("t1_rdata_held", 32'(a_rdata), 32'(8'h0A));
    chk("t1_busy_idle", 32'(busy), 32'(0));

    // 2: B writes 0x5C to 0x7 (acks old 0x00), then reads it back
    base = we_cnt;
    push(1'b1, 8'h00);
    set_b(1'b1, 1'b1, 4'h7, 8'h5C);
    wait_acks(1);
    b_req = 1'b0;
    chk("t2_we_cycles", 32'(we_cnt), 32'(base + 1));
    idle_cycles(1);
    push(1'b1, 8'h5C);
    set_b(1'b1, 1'b0, 4'h7, 8'h00);
    wait_acks(1);
    b_req = 1'b0;
    idle_cycles(2);

    // 3: both held from reset -> A, B, A, B
    reset = 1'b1;
    set_a(1'b1, 1'b0, 4'hE, 8'h00);
    set_b(1'b1, 1'b0, 4'h5, 8'h00);
    idle_cycles(1);
    reset = 1'b0;
    push(1'b0, 8'h0A); push(1'b1, 8'h55); push(1'b0, 8'h0A); push(1'b1, 8'h55);
    wait_acks(4);
    a_req = 1'b0;
    b_req = 1'b0;
    chk("t3_grant_b", 32'(grant_b), 32'(1));
    idle_cycles(3);

    // 4: A rd 0x0 vs held B; A's repeat request waits behind B
    push(1'b0, 8'h1F); push(1'b1, 8'h55); push(1'b0, 8'h1F);
    set_a(1'b1, 1'b0, 4'h0, 8'h00);
    set_b(1'b1, 1'b0, 4'h5, 8'h00);
    wait_acks(2);
    b_req = 1'b0;
    wait_acks(1);
    a_req = 1'b0;
    idle_cycles(2);

    // 5: reset during ISSUE of a write to 0x3 aborts it
    set_a(1'b1, 1'b1, 4'h3, 8'hEE);
    idle_cycles(1);
    chk("t5_we_issue", 32'(ram_we), 32'(1));
    reset = 1'b1;
    #1;
    chk("t5_we_abort", 32'(ram_we), 32'(0));
    chk("t5_busy_abort", 32'(busy), 32'(0));
    a_req = 1'b0;
    base = ack_cnt;
    idle_cycles(1);
    reset = 1'b0;
    idle_cycles(4);
    chk("t5_no_ack", 32'(ack_cnt), 32'(base));
    push(1'b0, 8'h86);
    set_a(1'b1, 1'b0, 4'h3, 8'h00);
    wait_acks(1);
    a_req = 1'b0;
    idle_cycles(2);

    // 6: A drops req during DATA; ack still pulses exactly once
    push(1'b0, 8'h55);
    set_a(1'b1, 1'b0, 4'h5, 8'h00);
    idle_cycles(2);
    chk("t6_busy_data", 32'(busy), 32'(1));
    a_req = 1'b0;
    base = ack_cnt;
    wait_acks(1);
    idle_cycles(4);
    chk("t6_one_ack", 32'(ack_cnt), 32'(base + 1));
    chk("t6_idle", 32'(busy), 32'(0));

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
